// File: rtl/shift_load_ctrl.sv
// shift_load_ctrl: accepts parallel words over valid/ready, issues one load pulse per
// word to the downstream shift_register, then exactly WIDTH shift pulses.
// Optional build macro SHIFT_LOAD_CTRL_PREFETCH_EN adds a one-entry prefetch register
// so the next word can be loaded directly after the last shift of the current one.
module shift_load_ctrl #(
   parameter int unsigned WIDTH    = 5,
   parameter logic        FILL_BIT = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [WIDTH-1:0] sr_load_data,
   output logic             sr_load,
   output logic             sr_shift,
   output logic             sr_shift_in,
   output logic             busy,
   output logic             word_done
);

   localparam int unsigned   CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {
      StIdle,
      StLoad,
      StShift
   } state_e;

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [WIDTH-1:0]   load_data_q, load_data_d;
   logic               sr_load_q, sr_shift_q, busy_q, word_done_q;
   logic               accept;
   logic               last_shift;

`ifdef SHIFT_LOAD_CTRL_PREFETCH_EN
   logic               pf_valid_q, pf_valid_d;
   logic [WIDTH-1:0]   pf_data_q, pf_data_d;
`endif

   assign accept      = in_valid && in_ready;
   assign last_shift  = (state_q == StShift) && (cnt_q == CNT_LAST);
   assign sr_shift_in = FILL_BIT;

   // Ready decodes state directly; held low while reset is asserted.
   always_comb begin
      in_ready = 1'b0;
      if (!rst) begin
         if (state_q == StIdle) begin
            in_ready = 1'b1;
         end
`ifdef SHIFT_LOAD_CTRL_PREFETCH_EN
         else begin
            in_ready = !pf_valid_q;
         end
`endif
      end
   end

   // Next-state, counter and load-data selection.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      load_data_d = load_data_q;
`ifdef SHIFT_LOAD_CTRL_PREFETCH_EN
      pf_valid_d  = pf_valid_q;
      pf_data_d   = pf_data_q;
`endif
      unique case (state_q)
         StIdle: begin
            if (accept) begin
               state_d     = StLoad;
               load_data_d = in_data;
            end
         end
         StLoad: begin
            state_d = StShift;
            cnt_d   = '0;
`ifdef SHIFT_LOAD_CTRL_PREFETCH_EN
            if (accept) begin
               pf_valid_d = 1'b1;
               pf_data_d  = in_data;
            end
`endif
         end
         StShift: begin
            if (last_shift) begin
               // Counter parks at its last value; it is cleared again in StLoad.
               state_d = StIdle;
`ifdef SHIFT_LOAD_CTRL_PREFETCH_EN
               if (pf_valid_q) begin
                  state_d     = StLoad;
                  load_data_d = pf_data_q;
                  pf_valid_d  = 1'b0;
               end else if (accept) begin
                  // Empty prefetch slot: a word taken now goes straight to load.
                  state_d     = StLoad;
                  load_data_d = in_data;
               end
`endif
            end else begin
               cnt_d = cnt_q + 1'b1;
`ifdef SHIFT_LOAD_CTRL_PREFETCH_EN
               if (accept) begin
                  pf_valid_d = 1'b1;
                  pf_data_d  = in_data;
               end
`endif
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // State and registered outputs, derived from next state so they align with it.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StIdle;
         cnt_q       <= '0;
         load_data_q <= '0;
         sr_load_q   <= 1'b0;
         sr_shift_q  <= 1'b0;
         busy_q      <= 1'b0;
         word_done_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         load_data_q <= load_data_d;
         sr_load_q   <= (state_d == StLoad);
         sr_shift_q  <= (state_d == StShift);
         busy_q      <= (state_d != StIdle);
         word_done_q <= (state_d == StShift) && (cnt_d == CNT_LAST);
      end
   end

`ifdef SHIFT_LOAD_CTRL_PREFETCH_EN
   // Prefetch slot; contents are dropped on reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         pf_valid_q <= 1'b0;
         pf_data_q  <= '0;
      end else begin
         pf_valid_q <= pf_valid_d;
         pf_data_q  <= pf_data_d;
      end
   end
`endif

   assign sr_load_data = load_data_q;
   assign sr_load      = sr_load_q;
   assign sr_shift     = sr_shift_q;
   assign busy         = busy_q;
   assign word_done    = word_done_q;

endmodule

// File: tb/tb_shift_load_ctrl.sv
// Self-checking bench for shift_load_ctrl (WIDTH=5): vector table, directed corner
// sequences and a randomized run against a transaction-level timing model.
module tb_shift_load_ctrl;

   localparam int unsigned W = 5;
`ifdef SHIFT_LOAD_CTRL_PREFETCH_EN
   localparam logic PF = 1'b1;
`else
   localparam logic PF = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid;
   logic [W-1:0] in_data;
   logic         in_ready;
   logic [W-1:0] sr_load_data;
   logic         sr_load, sr_shift, sr_shift_in, busy, word_done;
   logic [4:0]   act;

   always #5 clk = ~clk;

   shift_load_ctrl #(.WIDTH(W), .FILL_BIT(1'b0)) dut (
      .clk          (clk),
      .rst          (rst),
      .in_data      (in_data),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .sr_load_data (sr_load_data),
      .sr_load      (sr_load),
      .sr_shift     (sr_shift),
      .sr_shift_in  (sr_shift_in),
      .busy         (busy),
      .word_done    (word_done)
   );

   assign act = {in_ready, sr_load, sr_shift, busy, word_done};

   // Downstream shift_register model.
   logic [W-1:0] sr_mdl = '0;
   always @(posedge clk) begin
      if (sr_load)       sr_mdl <= sr_load_data;
      else if (sr_shift) sr_mdl <= {sr_mdl[W-2:0], sr_shift_in};
   end

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   task automatic idle_wait();
      int k = 0;
      in_valid = 1'b0;
      while (!(in_ready === 1'b1 && busy === 1'b0) && k < 30) begin
         @(posedge clk); #1;
         k++;
      end
      check("idle_reach", 32'(k < 30), 32'd1);
   endtask

   typedef struct {
      logic         r;
      logic         v;
      logic [W-1:0] d;
      logic [4:0]   exp;     // {in_ready, sr_load, sr_shift, busy, word_done}
      logic [W-1:0] exp_ld;
   } vec_t;

   vec_t tbl[15];

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic         acc;
      int           n_acc, n_load, n_sh, n11, bad, n_done, n_ld;
      int           load_cyc[2];
      logic [W-1:0] load_dat[2];
      int           acc_cyc[2];
      bit           hit, ready_drop;
      bit           have, pend;
      int           acc_c, c, d;
      logic         e_act, e_ready, e_load, e_shift, e_done;
      logic [W-1:0] m_ld;

      rst = 1'b1; in_valid = 1'b0; in_data = '0;

      // Reset 3 cycles, single word 10101, then 11111 with reset on its first shift.
      tbl[0]  = '{1'b1, 1'b0, 5'b00000, 5'b00000, 5'b00000};
      tbl[1]  = '{1'b1, 1'b0, 5'b00000, 5'b00000, 5'b00000};
      tbl[2]  = '{1'b1, 1'b0, 5'b00000, 5'b00000, 5'b00000};
      tbl[3]  = '{1'b0, 1'b1, 5'b10101, 5'b10000, 5'b00000};
      tbl[4]  = '{1'b0, 1'b0, 5'b00000, {PF, 4'b1010}, 5'b10101};
      tbl[5]  = '{1'b0, 1'b0, 5'b00000, {PF, 4'b0110}, 5'b10101};
      tbl[6]  = '{1'b0, 1'b0, 5'b00000, {PF, 4'b0110}, 5'b10101};
      tbl[7]  = '{1'b0, 1'b0, 5'b00000, {PF, 4'b0110}, 5'b10101};
      tbl[8]  = '{1'b0, 1'b0, 5'b00000, {PF, 4'b0110}, 5'b10101};
      tbl[9]  = '{1'b0, 1'b0, 5'b00000, {PF, 4'b0111}, 5'b10101};
      tbl[10] = '{1'b0, 1'b1, 5'b11111, 5'b10000, 5'b10101};
      tbl[11] = '{1'b0, 1'b0, 5'b00000, {PF, 4'b1010}, 5'b11111};
      tbl[12] = '{1'b1, 1'b0, 5'b00000, 5'b00110, 5'b11111};
      tbl[13] = '{1'b0, 1'b0, 5'b00000, 5'b10000, 5'b00000};
      tbl[14] = '{1'b0, 1'b0, 5'b00000, 5'b10000, 5'b00000};

      for (int i = 0; i < 15; i++) begin
         rst = tbl[i].r; in_valid = tbl[i].v; in_data = tbl[i].d;
         @(negedge clk);
         check($sformatf("vec%0d_ctl", i), 32'(act), 32'(tbl[i].exp));
         check($sformatf("vec%0d_ld", i), 32'(sr_load_data), 32'(tbl[i].exp_ld));
         check($sformatf("vec%0d_fill", i), 32'(sr_shift_in), 32'd0);
         if (i == 10) check("sr_after_5_shifts", 32'(sr_mdl), 32'd0);
         @(posedge clk); #1;
      end
      in_valid = 1'b0;

      // Back-to-back words with in_valid held high.
      idle_wait();
      in_valid = 1'b1; in_data = 5'b10101;
      n_acc = 0; n_load = 0; ready_drop = 0;
      load_cyc[0] = 0; load_cyc[1] = 0; load_dat[0] = '0; load_dat[1] = '0;
      for (int k = 0; k < 30; k++) begin
         @(negedge clk);
         acc = in_valid && in_ready;
         if (sr_load) begin
            if (n_load < 2) begin
               load_cyc[n_load] = k;
               load_dat[n_load] = sr_load_data;
            end
            n_load++;
         end
         if (n_acc == 2 && busy && !in_ready) ready_drop = 1;
         @(posedge clk); #1;
         if (acc) begin
            n_acc++;
            if (n_acc == 1) in_data = 5'b01110;
            else            in_valid = 1'b0;
         end
      end
      check("b2b_loads", 32'(n_load), 32'd2);
      check("b2b_gap", 32'(load_cyc[1] - load_cyc[0]), PF ? 32'd6 : 32'd7);
      check("b2b_word0", 32'(load_dat[0]), 32'b10101);
      check("b2b_word1", 32'(load_dat[1]), 32'b01110);
`ifdef SHIFT_LOAD_CTRL_PREFETCH_EN
      check("b2b_ready_drop", 32'(ready_drop), 32'd1);
`endif

`ifndef SHIFT_LOAD_CTRL_PREFETCH_EN
      // Backpressure: 11111 held valid during SHIFT must wait for IDLE.
      idle_wait();
      in_valid = 1'b1; in_data = 5'b10101;
      n_acc = 0; n11 = 0; bad = 0; acc_cyc[0] = 0; acc_cyc[1] = 0;
      for (int k = 0; k < 30; k++) begin
         @(negedge clk);
         acc = in_valid && in_ready;
         if (acc && n_acc < 2) acc_cyc[n_acc] = k;
         if (busy && in_ready) bad++;
         if (sr_load && sr_load_data == 5'b11111) n11++;
         @(posedge clk); #1;
         if (acc) begin
            n_acc++;
            if (n_acc == 1) in_data = 5'b11111;
            else            in_valid = 1'b0;
         end
      end
      check("bp_accepts", 32'(n_acc), 32'd2);
      check("bp_accept_gap", 32'(acc_cyc[1] - acc_cyc[0]), 32'(W + 2));
      check("bp_ready_while_busy", 32'(bad), 32'd0);
      check("bp_loads_11111", 32'(n11), 32'd1);
`endif

      // Reset on the third shift cycle.
      idle_wait();
      in_valid = 1'b1; in_data = 5'b10101;
      n_acc = 0; n_sh = 0; hit = 0;
      for (int k = 0; k < 20 && !hit; k++) begin
         @(negedge clk);
         acc = in_valid && in_ready;
         if (sr_shift) n_sh++;
         if (n_sh == 3) begin
            rst = 1'b1; in_valid = 1'b0; hit = 1;
         end
         @(posedge clk); #1;
         if (acc && !hit) begin
            n_acc++;
            if (PF && n_acc == 1) in_data = 5'b01110;
            else                  in_valid = 1'b0;
         end
      end
      rst = 1'b0; in_valid = 1'b0;
      check("rst_mid_reached", 32'(hit), 32'd1);
      @(negedge clk);
      check("rst_mid_shift_off", 32'(sr_shift), 32'd0);
      n_done = 0; n_ld = 0;
      for (int k = 0; k < 10; k++) begin
         if (word_done) n_done++;
         if (sr_load)   n_ld++;
         @(negedge clk);
      end
      check("rst_mid_no_done", 32'(n_done), 32'd0);
      check("rst_mid_no_load", 32'(n_ld), 32'd0);
      @(posedge clk); #1;

`ifndef SHIFT_LOAD_CTRL_PREFETCH_EN
      // Randomized run against a cycle-offset timing model.
      rst = 1'b1; in_valid = 1'b0;
      repeat (2) begin @(posedge clk); #1; end
      rst = 1'b0; have = 0; pend = 0; m_ld = '0; c = 0; acc_c = 0;
      for (int k = 0; k < 600; k++) begin
         if (!pend) begin
            in_valid = ($urandom_range(0, 2) != 0);
            in_data  = W'($urandom);
            pend     = in_valid;
         end
         rst     = ($urandom_range(0, 79) == 0);
         d       = c - acc_c;
         e_act   = have && d >= 1 && d <= W + 1;
         e_ready = !rst && !e_act;
         e_load  = have && d == 1;
         e_shift = have && d >= 2 && d <= W + 1;
         e_done  = have && d == W + 1;
         @(negedge clk);
         check("rand_ctl", 32'(act), 32'({e_ready, e_load, e_shift, e_act, e_done}));
         check("rand_ld", 32'(sr_load_data), 32'(m_ld));
         @(posedge clk);
         if (rst) begin
            have = 0; m_ld = '0; pend = 0;
         end else if (in_valid && e_ready) begin
            have = 1; acc_c = c; m_ld = in_data; pend = 0;
         end
         #1;
         c++;
      end
      rst = 1'b0; in_valid = 1'b0;
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
